// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM for the RV64 datapath.
// Optional macro CTRL_PERF_COUNTERS_EN adds cycleCount/retiredCount outputs.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic funct7_5,
    input  logic selectedFlag,
    input  logic dataAck,
    output logic irLoad,
    output logic pcLoad,
    output logic pcSrc,
    output logic writeEnable_Registers,
    output logic writeEnable_DataMemory,
    output logic dataReq,
    output logic muxSelect_ImmVsDataout2,
    output logic muxSelect_SumVsReadData,
    output logic SumOrSub,
    output logic busy,
    output logic halted,
    output logic error
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycleCount,
    output logic [CNT_W-1:0] retiredCount
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, ERROR
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t state, state_n;
    class_t cls, cls_n;
    logic   sub, sub_n;
    logic [CNT_W-1:0] mem_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mem_cnt <= '0;
        end else begin
            state <= state_n;
            // Counter is held at zero outside MEM so it starts from zero on every entry.
            if (state != MEM)
                mem_cnt <= '0;
            else if (!dataAck)
                mem_cnt <= mem_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cls <= cls_n;
        sub <= sub_n;
    end

    always_comb begin
        state_n                 = state;
        cls_n                   = cls;
        sub_n                   = sub;
        irLoad                  = 1'b0;
        pcLoad                  = 1'b0;
        pcSrc                   = 1'b0;
        writeEnable_Registers   = 1'b0;
        writeEnable_DataMemory  = 1'b0;
        dataReq                 = 1'b0;
        muxSelect_ImmVsDataout2 = 1'b0;
        muxSelect_SumVsReadData = 1'b0;
        SumOrSub                = 1'b0;
        busy                    = 1'b0;
        halted                  = 1'b0;
        error                   = 1'b0;
        case (state)
            IDLE: if (start) state_n = FETCH;
            FETCH: begin
                busy    = 1'b1;
                irLoad  = 1'b1;
                state_n = DECODE;
            end
            DECODE: begin
                busy    = 1'b1;
                sub_n   = funct7_5;
                state_n = EXECUTE;
                case (opcode)
                    OP_R:      cls_n = CL_R;
                    OP_I:      cls_n = CL_I;
                    OP_LOAD:   cls_n = CL_LOAD;
                    OP_STORE:  cls_n = CL_STORE;
                    OP_BRANCH: cls_n = CL_BRANCH;
                    OP_SYSTEM: begin
                        // The halting instruction retires here so a restart fetches the next one.
                        pcLoad  = 1'b1;
                        state_n = HALT;
                    end
                    default:   state_n = ERROR;
                endcase
            end
            EXECUTE: begin
                busy = 1'b1;
                case (cls)
                    CL_R, CL_I:         state_n = WRITEBACK;
                    CL_LOAD, CL_STORE:  state_n = MEM;
                    default: begin
                        pcLoad  = 1'b1;
                        pcSrc   = selectedFlag;
                        state_n = FETCH;
                    end
                endcase
            end
            MEM: begin
                busy                   = 1'b1;
                dataReq                = 1'b1;
                writeEnable_DataMemory = (cls == CL_STORE);
                if (dataAck) begin
                    if (cls == CL_STORE) begin
                        pcLoad  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = WRITEBACK;
                    end
                end else if (mem_cnt == TIMEOUT_LAST) begin
                    state_n = ERROR;
                end
            end
            WRITEBACK: begin
                busy                    = 1'b1;
                writeEnable_Registers   = 1'b1;
                muxSelect_SumVsReadData = (cls == CL_LOAD);
                pcLoad                  = 1'b1;
                state_n                 = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (start) state_n = FETCH;
            end
            default: error = 1'b1;
        endcase
        // ALU controls stay asserted past EXECUTE: the ALU is combinational, so the memory
        // address and the writeback result depend on them until the instruction retires.
        if (state == EXECUTE || state == MEM || state == WRITEBACK) begin
            muxSelect_ImmVsDataout2 = (cls == CL_I) || (cls == CL_LOAD) || (cls == CL_STORE);
            SumOrSub                = ((cls == CL_R) && sub) || (cls == CL_BRANCH);
        end
        // A reset cycle must never commit a register, memory or PC update.
        if (reset) begin
            irLoad                  = 1'b0;
            pcLoad                  = 1'b0;
            pcSrc                   = 1'b0;
            writeEnable_Registers   = 1'b0;
            writeEnable_DataMemory  = 1'b0;
            dataReq                 = 1'b0;
            muxSelect_ImmVsDataout2 = 1'b0;
            muxSelect_SumVsReadData = 1'b0;
            SumOrSub                = 1'b0;
            busy                    = 1'b0;
            halted                  = 1'b0;
            error                   = 1'b0;
        end
    end

`ifdef CTRL_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount   <= '0;
            retiredCount <= '0;
        end else begin
            if (busy)   cycleCount   <= cycleCount + 1'b1;
            if (pcLoad) retiredCount <= retiredCount + 1'b1;
        end
    end
`endif

    logic unused_funct3;
    assign unused_funct3 = ^funct3;

endmodule
